bt_rx_ctrl: RTL

BT_RX_CTRL -- requirements
Module: bt_rx_ctrl

---
 rtl/bt_rx_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/bt_rx_ctrl.sv
// bt_rx_ctrl: frame receiver for a UART byte stream.
// Frame: 0xAA, CMD, LEN, LEN payload bytes, then CHK (only when
// BT_RX_CHECKSUM_EN is defined; CHK = XOR of CMD, LEN, payload).
// Ports: clk_in, reset (async, active-low); rx_data/rx_valid in;
// cmd/len/payload/cmd_valid out, cmd_ack in; frame_err pulse; busy.
module bt_rx_ctrl #(
  parameter int MAX_LEN     = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           cmd,
  output logic [2:0]           len,
  output logic [8*MAX_LEN-1:0] payload,
  output logic                 cmd_valid,
  input  logic                 cmd_ack,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

`ifdef BT_RX_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, GET_CMD, GET_LEN, GET_DATA, GET_CHK, HOLD
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, GET_CMD, GET_LEN, GET_DATA, HOLD
  } state_t;
`endif

  state_t state_q, state_d;

  logic [7:0]           cmd_q, cmd_d;
  logic [2:0]           len_q, len_d;
  logic [8*MAX_LEN-1:0] pay_q, pay_d;
  logic                 err_q, err_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  // Staging copies: outputs only change when a frame is accepted.
  logic [7:0]           scmd_q, scmd_d;
  logic [2:0]           slen_q, slen_d;
  logic [8*MAX_LEN-1:0] sbuf_q, sbuf_d;
`ifdef BT_RX_CHECKSUM_EN
  logic [7:0]           chk_q, chk_d;
`endif

  logic idle_st;
  logic timeout;
  logic accept;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    len_d   = len_q;
    pay_d   = pay_q;
    scmd_d  = scmd_q;
    slen_d  = slen_q;
    sbuf_d  = sbuf_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    accept  = 1'b0;
`ifdef BT_RX_CHECKSUM_EN
    chk_d   = chk_q;
`endif

    idle_st = (state_q == IDLE) || (state_q == HOLD);
    cnt_d   = (rx_valid || idle_st) ? '0 : cnt_q + 1'b1;
    // A byte arriving in the expiry cycle wins over the timeout.
    timeout = !rx_valid && !idle_st && (cnt_q == TO_LAST);

    if (timeout) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rx_valid && rx_data == 8'hAA) begin
            state_d = GET_CMD;
            sbuf_d  = '0;
            idx_d   = '0;
          end
        end
        GET_CMD: begin
          if (rx_valid) begin
            scmd_d  = rx_data;
`ifdef BT_RX_CHECKSUM_EN
            chk_d   = rx_data;
`endif
            state_d = GET_LEN;
          end
        end
        GET_LEN: begin
          if (rx_valid) begin
            if (rx_data > 8'(MAX_LEN)) begin
              state_d = IDLE;
              err_d   = 1'b1;
            end else begin
              slen_d = rx_data[2:0];
              idx_d  = '0;
`ifdef BT_RX_CHECKSUM_EN
              chk_d  = chk_q ^ rx_data;
`endif
              if (rx_data == 8'd0) begin
`ifdef BT_RX_CHECKSUM_EN
                state_d = GET_CHK;
`else
                accept  = 1'b1;
`endif
              end else begin
                state_d = GET_DATA;
              end
            end
          end
        end
        GET_DATA: begin
          if (rx_valid) begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (idx_q == 3'(i)) sbuf_d[8*i +: 8] = rx_data;
            end
`ifdef BT_RX_CHECKSUM_EN
            chk_d = chk_q ^ rx_data;
`endif
            if (idx_q == slen_q - 3'd1) begin
`ifdef BT_RX_CHECKSUM_EN
              state_d = GET_CHK;
`else
              accept  = 1'b1;
`endif
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
`ifdef BT_RX_CHECKSUM_EN
        GET_CHK: begin
          if (rx_valid) begin
            if (rx_data == chk_q) begin
              accept = 1'b1;
            end else begin
              state_d = IDLE;
              err_d   = 1'b1;
            end
          end
        end
`endif
        HOLD: begin
          // Ack releases the frame; a same-cycle byte is seen as in IDLE.
          if (cmd_ack) begin
            state_d = IDLE;
            if (rx_valid && rx_data == 8'hAA) begin
              state_d = GET_CMD;
              sbuf_d  = '0;
              idx_d   = '0;
            end
          end else if (rx_valid) begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (accept) begin
      state_d = HOLD;
      cmd_d   = scmd_d;
      len_d   = slen_d;
      pay_d   = sbuf_d;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      len_q   <= '0;
      pay_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      scmd_q  <= '0;
      slen_q  <= '0;
      sbuf_q  <= '0;
`ifdef BT_RX_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      pay_q   <= pay_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      scmd_q  <= scmd_d;
      slen_q  <= slen_d;
      sbuf_q  <= sbuf_d;
`ifdef BT_RX_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign cmd       = cmd_q;
  assign len       = len_q;
  assign payload   = pay_q;
  assign frame_err = err_q;
  assign cmd_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);

endmodule
